bus_err_drain_arb: RTL and testbench

Drains the error FIFOs of several bare bus error units and serialises their entries onto one valid/ready report channel for a single register interface or CPU.
- Round-robin arbitration over units with a pending error.
- Pops exactly one entry per grant and holds it on the output until accepted.
- Keeps per-unit saturating overflow event counters.
- Sits between the bus error unit instances and the SoC control registers.

---
 rtl/bus_err_drain_arb.sv | 102 ++++++++++
 tb/tb_bus_err_drain_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_err_drain_arb.sv
// bus_err_drain_arb: round-robin drain of bus error unit FIFOs onto one valid/ready report channel
module bus_err_drain_arb #(
  parameter int NumUnits      = 4,
  parameter int AddrWidth     = 48,
  parameter int MetaDataWidth = 1,
  parameter int ErrBits       = 3,
  parameter int CntWidth      = 8,
  localparam int IdxWidth     = (NumUnits > 1) ? $clog2(NumUnits) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              enable_i,
  input  logic                              clear_cnt_i,
  input  logic [NumUnits-1:0]               unit_irq_i,
  input  logic [NumUnits*ErrBits-1:0]       unit_code_i,
  input  logic [NumUnits*AddrWidth-1:0]     unit_addr_i,
  input  logic [NumUnits*MetaDataWidth-1:0] unit_meta_i,
  input  logic [NumUnits-1:0]               unit_overflow_i,
  output logic [NumUnits-1:0]               unit_pop_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [IdxWidth-1:0]               out_unit_o,
  output logic [ErrBits-1:0]                out_code_o,
  output logic [AddrWidth-1:0]              out_addr_o,
  output logic [MetaDataWidth-1:0]          out_meta_o,
  output logic                              irq_o,
  output logic [NumUnits*CntWidth-1:0]      overflow_cnt_o
);
  typedef enum logic {IDLE, HOLD} state_e;
  state_e                                  state_q, state_d;
  logic [IdxWidth-1:0]                     ptr_q, ptr_d, unit_q, unit_d, win;
  logic [ErrBits-1:0]                      code_q, code_d;
  logic [AddrWidth-1:0]                    addr_q, addr_d;
  logic [MetaDataWidth-1:0]                meta_q, meta_d;
  logic [NumUnits-1:0]                     ovf_q, ovf_d;
  logic [NumUnits-1:0][CntWidth-1:0]       cnt_q, cnt_d;
  logic                                    found, grant;
  int                                      idx;
  // first requesting unit at or after the pointer, wrapping around
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NumUnits; k++) begin
      idx = int'(ptr_q) + k;
      idx = (idx >= NumUnits) ? idx - NumUnits : idx;
      if (!found && unit_irq_i[IdxWidth'(idx)]) begin
        found = 1'b1;
        win   = IdxWidth'(idx);
      end
    end
  end
  assign grant      = enable_i && (state_q == IDLE) && found;
  assign unit_pop_o = (grant && !rst_i) ? (NumUnits'(1) << win) : '0;
  // next-state, pointer advance and capture of the popped FIFO head
  always_comb begin
    state_d = grant ? HOLD : ((state_q == HOLD) && out_ready_i) ? IDLE : state_q;
    ptr_d   = grant ? ((win == IdxWidth'(NumUnits - 1)) ? '0 : win + 1'b1) : ptr_q;
    unit_d  = grant ? win : unit_q;
    code_d  = grant ? unit_code_i[win*ErrBits +: ErrBits] : code_q;
    addr_d  = grant ? unit_addr_i[win*AddrWidth +: AddrWidth] : addr_q;
    meta_d  = grant ? unit_meta_i[win*MetaDataWidth +: MetaDataWidth] : meta_q;
  end
  // saturating overflow event counters driven by rising edges of the FIFO-full flags
  always_comb begin
    ovf_d = unit_overflow_i;
    cnt_d = cnt_q;
    for (int i = 0; i < NumUnits; i++)
      cnt_d[i] = clear_cnt_i ? '0
               : (unit_overflow_i[i] && !ovf_q[i] && !(&cnt_q[i])) ? cnt_q[i] + 1'b1
               : cnt_q[i];
  end
  // all state, including the held report, is discarded on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      unit_q  <= '0;
      code_q  <= '0;
      addr_q  <= '0;
      meta_q  <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      unit_q  <= unit_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      meta_q  <= meta_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
  assign out_valid_o    = (state_q == HOLD);
  assign irq_o          = out_valid_o;
  assign out_unit_o     = unit_q;
  assign out_code_o     = code_q;
  assign out_addr_o     = addr_q;
  assign out_meta_o     = meta_q;
  assign overflow_cnt_o = cnt_q;
endmodule

// File: tb/tb_bus_err_drain_arb.sv
// tb_bus_err_drain_arb: directed table and sequence checks for the error drain arbiter
module tb_bus_err_drain_arb;
  logic        clk = 1'b0, rst, en, clr, rdy;
  logic [3:0]  irq, ovf, pop;
  logic [11:0] code_bus;
  logic [191:0] addr_bus;
  logic [3:0]  meta_bus;
  logic        valid, irq_out;
  logic [1:0]  unit;
  logic [2:0]  code;
  logic [47:0] addr;
  logic [0:0]  meta;
  logic [7:0]  cnt;
  logic [2:0]  code_tab [4];
  logic [47:0] addr_tab [4];
  logic        meta_tab [4];
  int          total = 0, passed = 0;

  typedef struct {
    logic       en;
    logic [3:0] irq;
    logic       rdy;
    logic [3:0] pop;
    logic       v;
    logic [1:0] u;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < 4; i++) begin
      code_bus[i*3 +: 3]  = code_tab[i];
      addr_bus[i*48 +: 48] = addr_tab[i];
      meta_bus[i]          = meta_tab[i];
    end

  bus_err_drain_arb #(.CntWidth(2)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_cnt_i(clr),
    .unit_irq_i(irq), .unit_code_i(code_bus), .unit_addr_i(addr_bus),
    .unit_meta_i(meta_bus), .unit_overflow_i(ovf), .unit_pop_o(pop),
    .out_valid_o(valid), .out_ready_i(rdy), .out_unit_o(unit),
    .out_code_o(code), .out_addr_o(addr), .out_meta_o(meta),
    .irq_o(irq_out), .overflow_cnt_o(cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; irq = '0; rdy = 1'b1; ovf = '0; clr = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [47:0] held;
    rst = 1'b1; en = 1'b0; irq = '0; rdy = 1'b0; ovf = '0; clr = 1'b0;
    code_tab = '{3'd3, 3'd1, 3'd5, 3'd7};
    addr_tab = '{48'hA000_0000_0000, 48'h0000_00BE_EF00, 48'h0000_0000_1234, 48'hFFFF_0000_0001};
    meta_tab = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[0]  = '{1'b0, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[3]  = '{1'b1, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[4]  = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[5]  = '{1'b1, 4'b1001, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[6]  = '{1'b1, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[7]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[8]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[9]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[10] = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[11] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[12] = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[13] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[14] = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[15] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_irq", irq_out, 0);
    chk("rst_pop", pop, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_data", {unit, code, addr, meta}, 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; irq = tbl[i].irq; rdy = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_pop", i), pop, tbl[i].pop);
      tick();
      chk($sformatf("tbl%0d_valid", i), valid, tbl[i].v);
      chk($sformatf("tbl%0d_irq", i), irq_out, tbl[i].v);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_unit", i), unit, tbl[i].u);
        chk($sformatf("tbl%0d_code", i), code, code_tab[tbl[i].u]);
        chk($sformatf("tbl%0d_addr", i), addr, addr_tab[tbl[i].u]);
        chk($sformatf("tbl%0d_meta", i), meta, meta_tab[tbl[i].u]);
      end
    end

    do_reset();
    en = 1'b1; irq = 4'b0100;
    #1;
    chk("single_pop", pop, 4'b0100);
    tick();
    chk("single_valid", valid, 1);
    chk("single_unit", unit, 2);
    chk("single_code", code, 5);
    chk("single_addr", addr, 48'h1234);
    irq = 4'b0000;
    #1;
    chk("single_hold_pop", pop, 0);
    tick();
    chk("single_drop", valid, 0);
    irq = 4'b1111;
    #1;
    chk("single_ptr3_pop", pop, 4'b1000);
    tick();
    chk("single_ptr3_unit", unit, 3);
    irq = 4'b0000;
    tick();

    do_reset();
    en = 1'b1; irq = 4'b0010; rdy = 1'b0;
    #1;
    chk("bp_pop", pop, 4'b0010);
    tick();
    chk("bp_valid", valid, 1);
    chk("bp_addr", addr, 48'h0000_00BE_EF00);
    held = 48'h0000_00BE_EF00;
    irq = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      addr_tab[1] = addr_tab[1] + 48'h1;
      #1;
      chk($sformatf("bp%0d_pop", i), pop, 0);
      tick();
      chk($sformatf("bp%0d_valid", i), valid, 1);
      chk($sformatf("bp%0d_addr", i), addr, held);
    end
    rdy = 1'b1;
    #1;
    chk("bp_accept_pop", pop, 0);
    tick();
    chk("bp_drop", valid, 0);
    #1;
    chk("bp_next_pop", pop, 4'b0100);
    tick();
    chk("bp_next_unit", unit, 2);
    irq = 4'b0000;
    tick();

    do_reset();
    for (int i = 0; i < 5; i++) begin
      ovf = 4'b1000;
      tick();
      ovf = 4'b0000;
      tick();
      if (i == 0) chk("cnt_first", cnt, 8'h40);
    end
    chk("cnt_sat", cnt, 8'hC0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("cnt_clear", cnt, 0);
    ovf = 4'b1000;
    repeat (20) tick();
    chk("cnt_level", cnt, 8'h40);
    ovf = 4'b0000;
    tick();
    ovf = 4'b1000; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("cnt_clr_edge", cnt, 0);
    tick();
    chk("cnt_clr_lost", cnt, 0);
    ovf = 4'b0000;
    tick();

    do_reset();
    ovf = 4'b0001;
    tick();
    ovf = 4'b0000;
    chk("arst_cnt_pre", cnt, 8'h01);
    en = 1'b1; irq = 4'b1111; rdy = 1'b0;
    #1;
    chk("arst_grant_pop", pop, 4'b0001);
    tick();
    chk("arst_hold", valid, 1);
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_pop", pop, 0);
    chk("arst_cnt", cnt, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_first_pop", pop, 4'b0001);
    tick();
    chk("arst_first_unit", unit, 0);
    chk("arst_first_valid", valid, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
